n_bit_factorial: RTL and testbench



---
 rtl/n_bit_factorial.sv | 69 ++++++
 tb/tb_n_bit_factorial.sv | 122 ++++++++++++
 2 files changed

// File: rtl/n_bit_factorial.sv
// n_bit_factorial: iterative factorial engine, one multiply per clock, with sticky overflow.
module n_bit_factorial #(
  parameter int N = 4,
  localparam int W = 10 * N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] Number,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] Factorial,
  output logic         Overflow
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_n;
  logic [W-1:0] acc, acc_n, fact_n;
  logic [N-1:0] cnt, cnt_n;
  logic ovf, ovf_n, oflag_n, done_n;
  logic [W+N-1:0] prod;
  assign prod = {{N{1'b0}}, acc} * {{W{1'b0}}, cnt};
  assign busy = state == CALC;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc <= W'(1);
      cnt <= '0;
      ovf <= 1'b0;
      Factorial <= '0;
      Overflow <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      Factorial <= fact_n;
      Overflow <= oflag_n;
      done <= done_n;
    end
  end
  // Counting down from the operand; anything the product spills above W bits marks overflow.
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    ovf_n = ovf;
    fact_n = Factorial;
    oflag_n = Overflow;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        cnt_n = Number;
        acc_n = W'(1);
        ovf_n = 1'b0;
        state_n = CALC;
      end
    end else if (cnt > N'(1)) begin
      acc_n = prod[W-1:0];
      ovf_n = ovf | (|prod[W+N-1:W]);
      cnt_n = cnt - N'(1);
    end else begin
      fact_n = acc;
      oflag_n = ovf;
      done_n = 1'b1;
      state_n = IDLE;
    end
  end
endmodule

// File: tb/tb_n_bit_factorial.sv
// tb_n_bit_factorial: directed stimulus with a queued scoreboard checked by a done-driven monitor.
module tb_n_bit_factorial;
  localparam int N = 4;
  localparam int W = 40;
  typedef struct {
    logic [W-1:0] f;
    logic o;
    int acc_cyc;
    int lat;
  } exp_t;
  logic clk = 0, rst = 1, start = 0;
  logic [N-1:0] Number = '0;
  logic busy, done, Overflow;
  logic [W-1:0] Factorial;
  int total = 0, bad = 0, cyc = 0;
  exp_t q[$];
  logic [W-1:0] held = '0;
  logic held_o = 0;

  n_bit_factorial #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .Number(Number),
    .busy(busy), .done(done), .Factorial(Factorial), .Overflow(Overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held = '0;
      held_o = 0;
    end else if (done) begin
      if (q.size() == 0) check("unexpected_done", done, 0);
      else begin
        e = q.pop_front();
        check("factorial", Factorial, e.f);
        check("overflow", Overflow, e.o);
        check("latency", cyc - e.acc_cyc, e.lat);
        held = e.f;
        held_o = e.o;
      end
    end else begin
      check("held_fact", Factorial, held);
      check("held_ovf", Overflow, held_o);
    end
  end

  task automatic issue(input logic [N-1:0] n, input logic [W-1:0] f, input logic o, input bit push);
    int t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", busy, 0);
    start = 1;
    Number = n;
    if (push) q.push_back('{f, o, cyc + 1, (n == 0) ? 1 : int'(n)});
    @(negedge clk);
    start = 0;
  endtask

  initial begin
    int t;
    #2;
    check("rst_fact", Factorial, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    #10 rst = 0;
    @(negedge clk);
    issue(3, 40'd6, 0, 1);
    issue(10, '0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1;
    #1;
    check("midrst_fact", Factorial, 0);
    check("midrst_ovf", Overflow, 0);
    check("midrst_done", done, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    issue(0, 40'd1, 0, 1);
    issue(1, 40'd1, 0, 1);
    issue(2, 40'd2, 0, 1);
    issue(4, 40'd24, 0, 1);
    issue(5, 40'd120, 0, 1);
    issue(8, 40'd40320, 0, 1);
    issue(9, 40'd362880, 0, 1);
    issue(10, 40'd3628800, 0, 1);
    issue(14, 40'd87178291200, 0, 1);
    issue(15, 40'd208162740224, 1, 1);
    issue(3, 40'd6, 0, 1);
    issue(15, 40'd208162740224, 1, 1);
    for (int i = 0; i < 14; i++) begin
      check("busy_hold", busy, 1);
      start = (i == 2);
      Number = (i == 2) ? 4'd2 : 4'($urandom);
      @(negedge clk);
    end
    start = 0;
    issue(7, 40'd5040, 0, 1);
    t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    check("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
